// File: rtl/answer_generator_if.sv
// Handshake bundle between the guess-checking block and the answer generator.
// The master drives start and the free-running counters; the slave returns the secret digits and game status.
interface answer_generator_if;
    logic       start;
    logic [2:0] round;
    logic [2:0] incorrect_guess;
    logic [3:0] answer0;
    logic [3:0] answer1;
    logic [3:0] answer2;
    logic [1:0] max_digit;
    logic       answer_valid;
    logic       game_over;
    logic       game_won;

    modport master (
        output start, round, incorrect_guess,
        input  answer0, answer1, answer2, max_digit, answer_valid, game_over, game_won
    );

    modport slave (
        input  start, round, incorrect_guess,
        output answer0, answer1, answer2, max_digit, answer_valid, game_over, game_won
    );
endinterface

// File: rtl/answer_generator.sv
// Secret-number generator for the guessing game.
// Draws BCD digits from a free-running LFSR and tracks round/miss progress against snapshot bases.
module answer_generator #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_ROUNDS = 3,
    parameter int          MAX_MISSES = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    answer_generator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GEN, READY, OVER} state_t;

    localparam logic [2:0] MAX_R = 3'(MAX_ROUNDS);
    localparam logic [2:0] MAX_M = 3'(MAX_MISSES);

    state_t      state_reg, state_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [2:0]  round_base_reg, round_base_next;
    logic [2:0]  miss_base_reg, miss_base_next;
    logic [2:0]  rd_prev_reg, rd_prev_next;
    logic [1:0]  d_reg, d_next;
    logic [1:0]  max_digit_reg, max_digit_next;
    logic [3:0]  answer_reg [3];
    logic [3:0]  answer_next [3];
    logic        valid_reg, valid_next;
    logic        over_reg, over_next;
    logic        won_reg, won_next;
    logic        gen_entry;

    logic [2:0] rounds_done;
    logic [2:0] misses;
    logic [3:0] nibble;

    // Differences against the bases make counter wrap-around harmless.
    assign rounds_done = bus.round - round_base_reg;
    assign misses      = bus.incorrect_guess - miss_base_reg;
    assign nibble      = lfsr_reg[3:0];

    always_comb begin
        state_next      = state_reg;
        lfsr_next       = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
        round_base_next = round_base_reg;
        miss_base_next  = miss_base_reg;
        rd_prev_next    = rd_prev_reg;
        d_next          = d_reg;
        max_digit_next  = max_digit_reg;
        valid_next      = valid_reg;
        over_next       = over_reg;
        won_next        = won_reg;
        gen_entry       = 1'b0;
        for (int i = 0; i < 3; i++) answer_next[i] = answer_reg[i];

        if (bus.start) begin
            state_next      = GEN;
            round_base_next = bus.round;
            miss_base_next  = bus.incorrect_guess;
            rd_prev_next    = 3'd0;
            d_next          = 2'd0;
            max_digit_next  = 2'd1;
            valid_next      = 1'b0;
            over_next       = 1'b0;
            won_next        = 1'b0;
            gen_entry       = 1'b1;
        end else begin
            case (state_reg)
                GEN: begin
                    // Nibbles 10..15 are retries; the LFSR keeps stepping regardless.
                    if (nibble <= 4'd9) begin
                        answer_next[d_reg] = nibble;
                        d_next             = d_reg + 2'd1;
                        if (d_reg + 2'd1 == max_digit_reg) begin
                            state_next = READY;
                            valid_next = 1'b1;
                        end
                    end
                end
                READY: begin
                    rd_prev_next = rounds_done;
                    if (rounds_done != rd_prev_reg) begin
                        valid_next = 1'b0;
                        if (rounds_done >= MAX_R) begin
                            state_next = OVER;
                            over_next  = 1'b1;
                            won_next   = 1'b1;
                        end else begin
                            state_next     = GEN;
                            d_next         = 2'd0;
                            max_digit_next = (rounds_done >= 3'd2) ? 2'd3 : rounds_done[1:0] + 2'd1;
                            gen_entry      = 1'b1;
                        end
                    end else if (misses >= MAX_M) begin
                        state_next = OVER;
                        valid_next = 1'b0;
                        over_next  = 1'b1;
                        won_next   = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        for (int i = 0; i < 3; i++) begin
            if (gen_entry && 2'(i) >= max_digit_next) answer_next[i] = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            lfsr_reg       <= SEED;
            round_base_reg <= 3'd0;
            miss_base_reg  <= 3'd0;
            rd_prev_reg    <= 3'd0;
            d_reg          <= 2'd0;
            max_digit_reg  <= 2'd0;
            valid_reg      <= 1'b0;
            over_reg       <= 1'b0;
            won_reg        <= 1'b0;
            for (int i = 0; i < 3; i++) answer_reg[i] <= 4'd0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            round_base_reg <= round_base_next;
            miss_base_reg  <= miss_base_next;
            rd_prev_reg    <= rd_prev_next;
            d_reg          <= d_next;
            max_digit_reg  <= max_digit_next;
            valid_reg      <= valid_next;
            over_reg       <= over_next;
            won_reg        <= won_next;
            for (int i = 0; i < 3; i++) answer_reg[i] <= answer_next[i];
        end
    end

    assign bus.answer0      = answer_reg[0];
    assign bus.answer1      = answer_reg[1];
    assign bus.answer2      = answer_reg[2];
    assign bus.max_digit    = max_digit_reg;
    assign bus.answer_valid = valid_reg;
    assign bus.game_over    = over_reg;
    assign bus.game_won     = won_reg;
endmodule

// File: tb/tb_answer_generator.sv
// Randomized bench for answer_generator: digits and timing are predicted from a precomputed LFSR
// sequence and a counting model of rounds and misses.
module tb_answer_generator;
    localparam int MAX_ROUNDS = 3;
    localparam int MAX_MISSES = 5;
    localparam int SEQ_LEN    = 8192;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    answer_generator_if bus();

    answer_generator #(
        .SEED(16'hACE1), .MAX_ROUNDS(MAX_ROUNDS), .MAX_MISSES(MAX_MISSES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; edge e sees LFSR value seq[e-1].
    int edge_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    logic [15:0] seq [SEQ_LEN];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  round_v, ig_v;
    int          rdone, miss_cnt, maxd_m;
    bit          over_m, won_m;
    logic [3:0]  exp_ans [3];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_answers(input string tag);
        check({tag, "_a0"}, 32'(bus.answer0), 32'(exp_ans[0]));
        check({tag, "_a1"}, 32'(bus.answer1), 32'(exp_ans[1]));
        check({tag, "_a2"}, 32'(bus.answer2), 32'(exp_ans[2]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a0"},    32'(bus.answer0), 0);
        check({tag, "_a1"},    32'(bus.answer1), 0);
        check({tag, "_a2"},    32'(bus.answer2), 0);
        check({tag, "_maxd"},  32'(bus.max_digit), 0);
        check({tag, "_valid"}, 32'(bus.answer_valid), 0);
        check({tag, "_over"},  32'(bus.game_over), 0);
        check({tag, "_won"},   32'(bus.game_won), 0);
    endtask

    task automatic check_over(input bit won);
        check("over_flag",  32'(bus.game_over), 1);
        check("over_won",   32'(bus.game_won), 32'(won));
        check("over_valid", 32'(bus.answer_valid), 0);
        check("over_maxd",  32'(bus.max_digit), 32'(maxd_m));
        check_answers("over_hold");
        over_m = 1'b1;
        won_m  = won;
    endtask

    // Generation entered at edge e draws digits from seq[e] onward; valid rises on edge e+lat.
    task automatic gen_check(input int e, input int maxd);
        int k, cnt, lat;
        bit got;
        logic [3:0] dig [3];
        for (int i = 0; i < 3; i++) dig[i] = 4'd0;
        cnt = 0;
        k = e;
        while (cnt < maxd && k < SEQ_LEN) begin
            if (seq[k][3:0] <= 4'd9) begin
                dig[cnt] = seq[k][3:0];
                cnt++;
            end
            k++;
        end
        lat = k - e;
        for (int i = 0; i < 3; i++) exp_ans[i] = dig[i];
        got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            tick();
            got = bus.answer_valid;
        end
        check("valid_seen", 32'(got), 1);
        if (got) check("valid_edge", edge_cnt, e + lat);
        check("ready_maxd", 32'(bus.max_digit), 32'(maxd));
        check("ready_over", 32'(bus.game_over), 0);
        check_answers("digits");
        $display("gen   edge=%0d maxd=%0d digits=%0d%0d%0d", edge_cnt, maxd, bus.answer2, bus.answer1, bus.answer0);
    endtask

    task automatic do_start(input logic [2:0] r, input logic [2:0] g);
        int e;
        round_v = r;
        ig_v    = g;
        bus.round           = r;
        bus.incorrect_guess = g;
        bus.start           = 1'b1;
        e = edge_cnt + 1;
        tick();
        bus.start = 1'b0;
        rdone = 0; miss_cnt = 0; maxd_m = 1; over_m = 1'b0; won_m = 1'b0;
        $display("start round=%0d miss=%0d", r, g);
        check("start_valid", 32'(bus.answer_valid), 0);
        check("start_maxd",  32'(bus.max_digit), 1);
        check("start_over",  32'(bus.game_over), 0);
        gen_check(e, 1);
    endtask

    task automatic do_advance(input bit also_miss);
        int e;
        round_v = round_v + 3'd1;
        bus.round = round_v;
        if (also_miss) begin
            ig_v = ig_v + 3'd1;
            bus.incorrect_guess = ig_v;
            miss_cnt++;
        end
        rdone++;
        e = edge_cnt + 1;
        tick();
        $display("adv   round=%0d done=%0d misses=%0d", round_v, rdone, miss_cnt);
        if (rdone >= MAX_ROUNDS) begin
            check_over(1'b1);
        end else begin
            maxd_m = (rdone + 1 > 3) ? 3 : rdone + 1;
            check("adv_valid", 32'(bus.answer_valid), 0);
            check("adv_maxd",  32'(bus.max_digit), 32'(maxd_m));
            check("adv_over",  32'(bus.game_over), 0);
            gen_check(e, maxd_m);
            if (miss_cnt >= MAX_MISSES) begin
                tick();
                check_over(1'b0);
            end
        end
    endtask

    task automatic do_miss();
        ig_v = ig_v + 3'd1;
        bus.incorrect_guess = ig_v;
        miss_cnt++;
        tick();
        $display("miss  guess=%0d misses=%0d", ig_v, miss_cnt);
        if (miss_cnt >= MAX_MISSES) begin
            check_over(1'b0);
        end else begin
            check("miss_valid", 32'(bus.answer_valid), 1);
            check("miss_over",  32'(bus.game_over), 0);
            check_answers("miss_hold");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.round = 3'd0;
        bus.incorrect_guess = 3'd0;
        seq[0] = 16'hACE1;
        for (int i = 1; i < SEQ_LEN; i++) seq[i] = lfsr_step(seq[i-1]);

        #12;
        check_zero("reset");
        #1 reset_n = 1'b1;
        tick();
        bus.round = 3'd5;
        tick();
        check_zero("idle");

        // First game from zeroed counters, then two advances and a win.
        do_start(3'd0, 3'd0);
        do_advance(1'b0);
        do_advance(1'b0);
        do_advance(1'b0);
        round_v = round_v + 3'd1;
        bus.round = round_v;
        tick();
        check_over(1'b1);

        // Counter wrap on both inputs, ending in a loss.
        do_start(3'd6, 3'd7);
        do_advance(1'b0);
        do_advance(1'b0);
        for (int i = 0; i < MAX_MISSES; i++) do_miss();

        // Round advance and miss limit together: the advance is taken first.
        do_start(3'd2, 3'd3);
        for (int i = 0; i < MAX_MISSES - 1; i++) do_miss();
        do_advance(1'b1);

        for (int g = 0; g < 15; g++) begin
            do_start(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            for (int s = 0; s < 25 && !over_m; s++) begin
                int a;
                a = $urandom_range(0, 9);
                if (a <= 2) begin
                    do_advance(1'($urandom_range(0, 3) == 0));
                end else if (a <= 6) begin
                    do_miss();
                end else if (a <= 8) begin
                    tick();
                    check("idle_valid", 32'(bus.answer_valid), 1);
                    check_answers("idle_hold");
                end else begin
                    // Start coinciding with a round change: start takes priority.
                    do_start(round_v + 3'd1, ig_v);
                end
            end
            if (over_m) begin
                round_v = round_v + 3'd1;
                bus.round = round_v;
                tick();
                check_over(won_m);
            end
        end

        // Asynchronous reset in the middle of generation, then a fresh game from the seed.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        #1 reset_n = 1'b1;
        check("reset_edges", edge_cnt, 0);
        do_start(3'd1, 3'd1);
        do_advance(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/answer_generator.md
ANSWER_GENERATOR -- requirements
Module: answer_generator

Interface
REQ-001 Parameter SEED, default 16'hACE1, nonzero LFSR load value at reset.
REQ-002 Parameter MAX_ROUNDS, default 3, rounds to win a game (1..7).
REQ-003 Parameter MAX_MISSES, default 5, incorrect guesses that end a game (1..7).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a new game, honoured in any non-reset state.
REQ-007 round  input  3  round counter from the guess-checking block; free-running, never cleared.
REQ-008 incorrect_guess  input  3  miss counter from the guess-checking block; free-running, never cleared.
REQ-009 answer0, answer1, answer2  output  4 each  secret digits, BCD 0..9; answer0 is least significant.
REQ-010 max_digit  output  2  active digit count for the current round, 1..3; 0 only when idle.
REQ-011 answer_valid  output  1  high while answers are stable and may be compared.
REQ-012 game_over  output  1  high when the game has ended.
REQ-013 game_won  output  1  qualifies game_over: 1 = won, 0 = lost.

Function
REQ-014 The block SHALL run a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), stepping every clock in every state, loaded with SEED on reset.
REQ-015 The FSM SHALL have states IDLE, GEN, READY, OVER; reset enters IDLE.
REQ-016 IDLE: answers 0, max_digit 0, answer_valid 0, game_over 0, game_won 0; start -> GEN.
REQ-017 On start from any state, the block SHALL latch round_base <= round, miss_base <= incorrect_guess, set max_digit <= 1, clear game_over/game_won/answer_valid, enter GEN.
REQ-018 rounds_done SHALL be (round - round_base) mod 8 and misses SHALL be (incorrect_guess - miss_base) mod 8, so counter wrap-around is harmless.
REQ-019 GEN: a digit index d starts at 0; each cycle, if lfsr[3:0] <= 9 the value SHALL be written to answer[d] and d increments, otherwise the cycle is a retry with no write.
REQ-020 GEN: digits with index >= max_digit SHALL be forced to 0 on GEN entry.
REQ-021 GEN: when d reaches max_digit, the FSM SHALL enter READY; answer_valid rises the cycle READY is entered; answer_valid SHALL be 0 throughout GEN.
REQ-022 GEN: a change of round or incorrect_guess during GEN SHALL be ignored except as counted via REQ-018 on return to READY.
REQ-023 READY: a cycle with rounds_done differing from its registered previous value is a round advance.
REQ-024 Round advance with rounds_done >= MAX_ROUNDS SHALL enter OVER with game_won 1.
REQ-025 Other round advance SHALL set max_digit <= min(rounds_done+1, 3), clear answer_valid, enter GEN.
REQ-026 READY with no round advance and misses >= MAX_MISSES SHALL enter OVER with game_won 0.
REQ-027 Round advance and miss limit in the same cycle: round advance SHALL win.
REQ-028 OVER: answers and max_digit hold, answer_valid 0, game_over 1; only start or reset leaves OVER.
REQ-029 start in the same cycle as any other event SHALL take priority.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, all outputs 0, LFSR = SEED, bases and d = 0, independent of clk.
REQ-031 Reset asserted mid-GEN or mid-READY SHALL discard the game; release requires a new start.
REQ-032 The first rising edge after reset_n deasserts SHALL be a normal operating edge.

Verification
REQ-033 Reset, then start with round=0, incorrect_guess=0 -> GEN; answer_valid 1 within 20 cycles; max_digit 1; answer0 <= 9; answer1=answer2=0.
REQ-034 Hold LFSR nibble sequence from SEED 16'hACE1 in model; step round 0->1->2 with answer_valid high each time -> max_digit 2 then 3; every produced digit equals the model's first in-range nibble(s).
REQ-035 From READY, round advances to rounds_done=3 with MAX_ROUNDS 3 -> OVER, game_over 1, game_won 1, answers held.
REQ-036 start at round=6, incorrect_guess=7; incorrect_guess wraps to 4 (misses=5) -> OVER, game_won 0; round wrap 7->0 counts as one advance.
REQ-037 Round advance and miss limit in same cycle -> GEN with max_digit incremented, no game_over.
REQ-038 reset_n pulsed low between clock edges during GEN -> outputs 0 before next edge; start afterwards regenerates from SEED.
